// File: rtl/seg7_pkg.sv
// Shared types, constants and hex-to-segment table for the seven-segment scanner.
package seg7_pkg;

    typedef logic [6:0] seg_t;   // active-low {g,f,e,d,c,b,a}
    typedef logic [2:0] pos_t;   // digit position 0..7

    // ST_SYNC covers the single cycle after reset release in which the first
    // snapshot is taken; ST_SCAN is normal dwell/position cycling.
    typedef enum logic {
        ST_SYNC,
        ST_SCAN
    } scan_state_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic seg_t hex2seg(input logic [3:0] h);
        return HEX_SEG[h];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);

    // table lookup of the hex glyph
    always_comb begin
        seg = hex2seg(nib);
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit seven-segment scanner with per-frame input snapshot.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN: darkens the high digit of the
// (pos1,pos0) and (pos5,pos4) pairs when that digit is zero.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] anodo_en,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    output logic [7:0] anodo,
    output logic [6:0] seg,
    output logic       frame_start
);

    localparam int DWELL_CYCLES = CLK_HZ / (REFRESH_HZ * 8);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    generate
        if (DWELL_CYCLES <= BLANK_CYCLES) begin : g_bad_cfg
            $error("seg7_scan: DWELL_CYCLES must exceed BLANK_CYCLES");
        end
    endgenerate

    scan_state_t   state;
    logic [CW-1:0] cnt;
    pos_t          pos;
    logic [7:0]    snap_mask;
    logic [3:0]    snap_d1, snap_d2, snap_d3, snap_d4;
    logic [3:0]    digit;
    seg_t          dec_seg;
    logic [7:0]    anodo_nxt;
    seg_t          seg_nxt;

    // position to snapshotted digit routing; unused positions carry 0
    always_comb begin
        digit = 4'h0;
        case (pos)
            3'd0:    digit = snap_d4;
            3'd1:    digit = snap_d3;
            3'd4:    digit = snap_d2;
            3'd5:    digit = snap_d1;
            default: digit = 4'h0;
        endcase
    end

    seg7_decode u_decode (
        .nib (digit),
        .seg (dec_seg)
    );

    // next anode/segment drive from the current counter state
    always_comb begin
        anodo_nxt = '1;
        seg_nxt   = SEG_BLANK;
        if (state == ST_SCAN && cnt >= CNT_BLANK) begin
            anodo_nxt = ~(8'b1 << pos) | snap_mask;
            seg_nxt   = dec_seg;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if ((pos == 3'd1 || pos == 3'd5) && digit == 4'h0) begin
                anodo_nxt = '1;
                seg_nxt   = SEG_BLANK;
            end
`endif
        end
    end

    // scan FSM: dwell counter, position, snapshot and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SYNC;
            cnt         <= '0;
            pos         <= '0;
            snap_mask   <= '1;
            snap_d1     <= '0;
            snap_d2     <= '0;
            snap_d3     <= '0;
            snap_d4     <= '0;
            anodo       <= '1;
            seg         <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            anodo       <= anodo_nxt;
            seg         <= seg_nxt;
            frame_start <= 1'b0;
            case (state)
                // counter is held at pos0/count0 here so the first frame
                // after reset has the same pulse alignment as every later one
                ST_SYNC: begin
                    snap_mask   <= anodo_en;
                    snap_d1     <= d1;
                    snap_d2     <= d2;
                    snap_d3     <= d3;
                    snap_d4     <= d4;
                    frame_start <= 1'b1;
                    state       <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        pos <= pos + 3'd1;
                        if (pos == 3'd7) begin
                            snap_mask   <= anodo_en;
                            snap_d1     <= d1;
                            snap_d2     <= d2;
                            snap_d3     <= d3;
                            snap_d4     <= d4;
                            frame_start <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan (DWELL_CYCLES=10, BLANK_CYCLES=2).
module tb_seg7_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] anodo_en;
    logic [3:0] d1, d2, d3, d4;
    logic [7:0] anodo;
    logic [6:0] seg;
    logic       frame_start;

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    // expected anode drive and segments during the SHOW phase of each slot
    logic [7:0] exp_an [8];
    logic [6:0] exp_sg [8];

    seg7_scan #(
        .CLK_HZ       (800),
        .REFRESH_HZ   (10),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .anodo_en    (anodo_en),
        .d1          (d1),
        .d2          (d2),
        .d3          (d3),
        .d4          (d4),
        .anodo       (anodo),
        .seg         (seg),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s: got %02h want %02h", tag, got, want);
        end
    endtask

    // after reset release, frame_start must appear one cycle later
    task automatic sync_reset();
        int lat;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (frame_start) begin
                lat = i;
                break;
            end
        end
        chk("fs_latency", 8'(lat), 8'd1);
    endtask

    // called in a frame_start cycle; checks 80 cycles and ends in the next one
    task automatic check_frame(input int chg_at);
        int p, c;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            p = k / 10;
            c = k % 10;
            if (c < 2) begin
                chk($sformatf("an_blank p%0d c%0d", p, c), anodo, 8'hFF);
                chk($sformatf("sg_blank p%0d c%0d", p, c), {1'b0, seg}, 8'h7F);
            end else begin
                chk($sformatf("an p%0d c%0d", p, c), anodo, exp_an[p]);
                if (exp_an[p] != 8'hFF)
                    chk($sformatf("sg p%0d c%0d", p, c), {1'b0, seg}, {1'b0, exp_sg[p]});
            end
            chk($sformatf("fs k%0d", k), {7'b0, frame_start}, (k == 79) ? 8'h01 : 8'h00);
            if (k == chg_at) d4 = 4'h8;
        end
    endtask

    initial begin
        anodo_en = ~8'h33;
        d1 = 4'h1; d2 = 4'h2; d3 = 4'h3; d4 = 4'h4;

        // reset hold
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an", anodo, 8'hFF);
        chk("rst_sg", {1'b0, seg}, 8'h7F);
        chk("rst_fs", {7'b0, frame_start}, 8'h00);
        rst_n = 1'b1;
        sync_reset();

        // default mask, two frames
        exp_an = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hEF, 8'hDF, 8'hFF, 8'hFF};
        exp_sg = '{7'h19, 7'h30, 7'h7F, 7'h7F, 7'h24, 7'h79, 7'h7F, 7'h7F};
        check_frame(-1);
        check_frame(-1);

        // result-only: current frame keeps the old snapshot
        anodo_en = ~8'h03; d3 = 4'hA; d4 = 4'hF;
        check_frame(-1);
        exp_an = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp_sg = '{7'h0E, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        check_frame(-1);

        // all disabled: transitional frame, then three dark frames
        anodo_en = 8'hFF;
        check_frame(-1);
        exp_an = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int f = 0; f < 3; f++) check_frame(-1);

        // mid-frame change of d4 during pos2
        anodo_en = ~8'h33;
        d1 = 4'h1; d2 = 4'h2; d3 = 4'h3; d4 = 4'h4;
        check_frame(-1);
        exp_an = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hEF, 8'hDF, 8'hFF, 8'hFF};
        exp_sg = '{7'h19, 7'h30, 7'h7F, 7'h7F, 7'h24, 7'h79, 7'h7F, 7'h7F};
        check_frame(25);
        exp_sg[0] = 7'h00;
        check_frame(-1);

        // async reset during pos4 SHOW
        repeat (46) @(negedge clk);
        chk("an_pre_rst", anodo, 8'hEF);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_an", anodo, 8'hFF);
        chk("arst_sg", {1'b0, seg}, 8'h7F);
        chk("arst_fs", {7'b0, frame_start}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sync_reset();
        check_frame(-1);

        // leading-zero pair handling
        anodo_en = ~8'h03; d3 = 4'h0; d4 = 4'h7;
        check_frame(-1);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        exp_an = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
        exp_an = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif
        exp_sg = '{7'h78, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        check_frame(-1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
